// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the key gesture controller.
//   * 3-bit FSM state encodings
//   * default timing constants, in 50 MHz clock cycles
//   * timer width
package key_pkg;

   localparam int KEY_CNT_W = 26;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRESS1    = 3'd1,
      ST_WAIT2     = 3'd2,
      ST_PRESS2    = 3'd3,
      ST_LONG_HOLD = 3'd4
   } key_state_e;

   // Default timings at 50 MHz.
   localparam logic [KEY_CNT_W-1:0] KEY_DEBOUNCE_CNT = 26'd1_000_000;   // 20 ms, used by the key filter
   localparam logic [KEY_CNT_W-1:0] KEY_LONG_CNT     = 26'd50_000_000;  // 1 s
   localparam logic [KEY_CNT_W-1:0] KEY_DBL_GAP_CNT  = 26'd15_000_000;  // 300 ms
   localparam logic [KEY_CNT_W-1:0] KEY_REPEAT_CNT   = 26'd10_000_000;  // 200 ms

endpackage

// File: rtl/key_evt_timer.sv
// key_evt_timer -- clear/enable up-counter with a terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count enable
//   term       : terminal value; on reaching it the counter wraps to 0
//   tc         : high while enabled and the count equals term
module key_evt_timer #(
   parameter int CNT_W = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tc = en && (cnt_q == term);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl -- key gesture classifier (click / double click / long press).
// Consumes the debounce filter's one-cycle press/release flags and emits
// one-cycle event pulses one clock after the triggering flag or timeout.
//   clk, rst_n        : 50 MHz clock, asynchronous active-low reset
//   key_p_flag        : debounced press pulse
//   key_r_flag        : debounced release pulse
//   click_pulse       : single click
//   dbl_click_pulse   : double click
//   long_press_pulse  : long-press threshold reached
//   repeat_pulse      : auto-repeat tick while held (0 unless enabled)
//   busy              : FSM not idle
// Build option: define KEY_EVENT_CTRL_REPEAT_EN to enable auto-repeat in
// LONG_HOLD; otherwise repeat_pulse is tied low.
module key_event_ctrl
   import key_pkg::*;
#(
   parameter int               CNT_W       = KEY_CNT_W,
   parameter logic [CNT_W-1:0] LONG_CNT    = KEY_LONG_CNT,
   parameter logic [CNT_W-1:0] DBL_GAP_CNT = KEY_DBL_GAP_CNT,
   parameter logic [CNT_W-1:0] REPEAT_CNT  = KEY_REPEAT_CNT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_p_flag,
   input  logic key_r_flag,
   output logic click_pulse,
   output logic dbl_click_pulse,
   output logic long_press_pulse,
   output logic repeat_pulse,
   output logic busy
);

   key_state_e       state_q, state_d;
   logic             click_q, click_d;
   logic             dbl_q, dbl_d;
   logic             long_q, long_d;
   logic             tmr_clr, tmr_en, tmr_tc;
   logic [CNT_W-1:0] tmr_term;

   // One shared timer; its terminal value depends on which wait is running.
   always_comb begin
      case (state_q)
         ST_WAIT2:     tmr_term = DBL_GAP_CNT - CNT_W'(1);
         ST_LONG_HOLD: tmr_term = REPEAT_CNT - CNT_W'(1);
         default:      tmr_term = LONG_CNT - CNT_W'(1);
      endcase
   end

`ifdef KEY_EVENT_CTRL_REPEAT_EN
   logic rep_q, rep_d;
   assign tmr_en = (state_q == ST_PRESS1) || (state_q == ST_WAIT2) ||
                   (state_q == ST_PRESS2) || (state_q == ST_LONG_HOLD);
`else
   assign tmr_en = (state_q == ST_PRESS1) || (state_q == ST_WAIT2) ||
                   (state_q == ST_PRESS2);
`endif

   // Every state change restarts the timer from 0.
   assign tmr_clr = (state_d != state_q);

   key_evt_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .term  (tmr_term),
      .tc    (tmr_tc)
   );

   // Flags are tested before timeouts so a flag always wins a tie; this also
   // makes a press on the WAIT2 timeout cycle start PRESS2 without a click.
   always_comb begin
      state_d = state_q;
      click_d = 1'b0;
      dbl_d   = 1'b0;
      long_d  = 1'b0;
`ifdef KEY_EVENT_CTRL_REPEAT_EN
      rep_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (key_p_flag) state_d = ST_PRESS1;
         end
         ST_PRESS1: begin
            if (key_r_flag) begin
               state_d = ST_WAIT2;
            end else if (tmr_tc) begin
               state_d = ST_LONG_HOLD;
               long_d  = 1'b1;
            end
         end
         ST_WAIT2: begin
            if (key_p_flag) begin
               state_d = ST_PRESS2;
            end else if (tmr_tc) begin
               state_d = ST_IDLE;
               click_d = 1'b1;
            end
         end
         ST_PRESS2: begin
            if (key_r_flag) begin
               state_d = ST_IDLE;
               dbl_d   = 1'b1;
            end else if (tmr_tc) begin
               // First click already completed; the second press became a hold.
               state_d = ST_LONG_HOLD;
               click_d = 1'b1;
               long_d  = 1'b1;
            end
         end
         ST_LONG_HOLD: begin
            if (key_r_flag) begin
               state_d = ST_IDLE;
`ifdef KEY_EVENT_CTRL_REPEAT_EN
            end else if (tmr_tc) begin
               rep_d = 1'b1;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         click_q <= 1'b0;
         dbl_q   <= 1'b0;
         long_q  <= 1'b0;
`ifdef KEY_EVENT_CTRL_REPEAT_EN
         rep_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         click_q <= click_d;
         dbl_q   <= dbl_d;
         long_q  <= long_d;
`ifdef KEY_EVENT_CTRL_REPEAT_EN
         rep_q   <= rep_d;
`endif
      end
   end

   assign click_pulse      = click_q;
   assign dbl_click_pulse  = dbl_q;
   assign long_press_pulse = long_q;
   assign busy             = (state_q != ST_IDLE);
`ifdef KEY_EVENT_CTRL_REPEAT_EN
   assign repeat_pulse     = rep_q;
`else
   assign repeat_pulse     = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl -- randomized self-checking bench for key_event_ctrl.
// The reference model tracks the gesture phase and the edge at which it was
// entered; timeouts are elapsed-cycle arithmetic against the parameters.
module tb_key_event_ctrl;

   localparam int LONG = 100;
   localparam int GAP  = 40;
   localparam int REP  = 20;
`ifdef KEY_EVENT_CTRL_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_p_flag = 1'b0;
   logic key_r_flag = 1'b0;
   logic click_pulse, dbl_click_pulse, long_press_pulse, repeat_pulse, busy;

   always #5 clk = ~clk;

   key_event_ctrl #(
      .CNT_W       (26),
      .LONG_CNT    (26'd100),
      .DBL_GAP_CNT (26'd40),
      .REPEAT_CNT  (26'd20)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .key_p_flag       (key_p_flag),
      .key_r_flag       (key_r_flag),
      .click_pulse      (click_pulse),
      .dbl_click_pulse  (dbl_click_pulse),
      .long_press_pulse (long_press_pulse),
      .repeat_pulse     (repeat_pulse),
      .busy             (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got {busy,rep,long,dbl,click}=%b, expected %b", tag, $time, got, exp);
      end
   endtask

   // Reference model: phase 0 idle, 1 first press, 2 gap, 3 second press, 4 held.
   int         ph    = 0;
   int         t_en  = 0;
   int         now   = 0;
   logic [4:0] exp_o = '0;

   function automatic logic [4:0] dut_vec();
      return {busy, repeat_pulse, long_press_pulse, dbl_click_pulse, click_pulse};
   endfunction

   task automatic model(input bit p, input bit r);
      int el, nph;
      bit e_clk, e_dbl, e_long, e_rep;
      el = now - t_en;
      nph = ph;
      e_clk = 0; e_dbl = 0; e_long = 0; e_rep = 0;
      if (!rst_n) begin
         nph = 0;
      end else begin
         case (ph)
            0: if (p) nph = 1;
            1: if (r) nph = 2;
               else if (el == LONG) begin nph = 4; e_long = 1; end
            2: if (p) nph = 3;
               else if (el == GAP) begin nph = 0; e_clk = 1; end
            3: if (r) begin nph = 0; e_dbl = 1; end
               else if (el == LONG) begin nph = 4; e_clk = 1; e_long = 1; end
            default: if (r) nph = 0;
                     else if (REP_EN && el > 0 && (el % REP) == 0) e_rep = 1;
         endcase
      end
      if (nph != ph) t_en = now;
      ph = nph;
      exp_o = {ph != 0, e_rep, e_long, e_dbl, e_clk};
      now++;
   endtask

   // One clock: check outputs of the previous edge, drive flags, step model.
   task automatic cyc(input bit p, input bit r);
      @(negedge clk);
      chk("outs", dut_vec(), exp_o);
      key_p_flag = p;
      key_r_flag = r;
      @(posedge clk);
      model(p, r);
   endtask

   task automatic idle(input int n, input bit noise);
      for (int i = 0; i < n; i++)
         cyc(noise && ($urandom_range(0, 40) == 0), noise && ($urandom_range(0, 40) == 0));
   endtask

   task automatic press();   cyc(1'b1, $urandom_range(0, 7) == 0); endtask
   task automatic release_k(); cyc($urandom_range(0, 7) == 0, 1'b1); endtask

   initial begin
      #12;
      chk("reset", dut_vec(), 5'b0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_o = '0;

      // single click: click 41 cycles after release
      cyc(1, 0); idle(29, 0); cyc(0, 1); idle(60, 0);
      // double click
      cyc(1, 0); idle(29, 0); cyc(0, 1); idle(19, 0); cyc(1, 0); idle(19, 0); cyc(0, 1); idle(60, 0);
      // long press, held, released at 300
      cyc(1, 0); idle(299, 0); cyc(0, 1); idle(20, 0);
      // click then hold second press: click + long together
      cyc(1, 0); idle(4, 0); cyc(0, 1); idle(4, 0); cyc(1, 0); idle(110, 0); cyc(0, 1); idle(10, 0);
      // press on the exact WAIT2 timeout edge -> PRESS2, no click
      cyc(1, 0); idle(9, 0); cyc(0, 1); idle(39, 0); cyc(1, 0); idle(5, 0); cyc(0, 1); idle(60, 0);
      // simultaneous flags in each state
      cyc(1, 1); idle(3, 0); cyc(1, 1); idle(3, 0); cyc(1, 1); idle(3, 0); cyc(1, 1); idle(60, 0);

      // asynchronous reset in the middle of PRESS2
      cyc(1, 0); idle(5, 0); cyc(0, 1); idle(5, 0); cyc(1, 0); idle(10, 0);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", dut_vec(), 5'b0);
      model(0, 0);
      idle(3, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(80, 0);
      cyc(1, 0); idle(10, 0); cyc(0, 1); idle(60, 0);

      // randomized gestures with spurious flag noise
      for (int g = 0; g < 60; g++) begin
         press();
         idle($urandom_range(0, 130), $urandom_range(0, 3) == 0);
         release_k();
         idle($urandom_range(0, 60), $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) begin
            press();
            idle($urandom_range(0, 130), 0);
            release_k();
         end
         idle($urandom_range(0, 60), $urandom_range(0, 1) == 0);
      end
      idle(120, 0);

      @(negedge clk);
      chk("final", dut_vec(), exp_o);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
